// File: rtl/msu_data_feeder.sv
// msu_data_feeder
// Upstream stage of the MSU register block. Streams MCU bytes for a data seek
// into the 16 KiB MSU data buffer, manages refills of the two buffer halves
// while the SNES reads, and performs the seek handshake (preset read address,
// then clear data_busy).
//
// Ports:
//   clkin, reset           system clock, async active-high reset
//   data_start_in          data seek request level (rising edge starts a seek)
//   snes_rd_addr           current SNES read address into the buffer
//   mcu_byte/_strobe       MCU byte and its one-cycle valid strobe
//   fill_req, fill_half    request to the MCU and the half being filled
//   pgm_address/data/we    buffer write port (we active-low)
//   msu_address_ext/_write read-address preset and its strobe
//   status_reset_bits/_set_bits/_reset_we   status register update
//   underrun, overflow     sticky error flags, cleared by a new seek
//
// state   | meaning
// IDLE    | no seek active
// PREFILL | filling the whole buffer from address 0
// SEEK    | pulsing the read-address preset, then one idle cycle
// RELEASE | pulsing the status clear (data_busy), then mask back to 0
// STREAM  | refilling halves the SNES read pointer has left
module msu_data_feeder #(
    parameter int HALF_BYTES = 8192,
    parameter int PULSE_LEN  = 3
) (
    input  logic        clkin,
    input  logic        reset,
    input  logic        data_start_in,
    input  logic [13:0] snes_rd_addr,
    input  logic [7:0]  mcu_byte,
    input  logic        mcu_byte_strobe,
    output logic        fill_req,
    output logic        fill_half,
    output logic [13:0] pgm_address,
    output logic [7:0]  pgm_data,
    output logic        pgm_we,
    output logic [13:0] msu_address_ext,
    output logic        msu_address_ext_write,
    output logic [5:0]  status_reset_bits,
    output logic [5:0]  status_set_bits,
    output logic        status_reset_we,
    output logic        underrun,
    output logic        overflow
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PREFILL = 3'd1;
    localparam logic [2:0] S_SEEK    = 3'd2;
    localparam logic [2:0] S_RELEASE = 3'd3;
    localparam logic [2:0] S_STREAM  = 3'd4;

    localparam logic [14:0] PRE_LAST     = 15'(2 * HALF_BYTES - 1);
    localparam logic [14:0] HALF_LAST    = 15'(HALF_BYTES - 1);
    localparam logic [7:0]  TMR_LOAD     = 8'(PULSE_LEN - 1);
    localparam logic [5:0]  RELEASE_MASK = 6'b010000;

    logic [2:0]  state_q, state_d;
    logic        start_q;
    logic        rd_half_q;
    logic [13:0] wptr_q, wptr_d;
    logic [14:0] cnt_q, cnt_d;
    logic [7:0]  tmr_q, tmr_d;
    logic [1:0]  pend_q, pend_d;
    logic        fill_req_q, fill_req_d;
    logic        fill_half_q, fill_half_d;
    logic [13:0] pgm_addr_q, pgm_addr_d;
    logic [7:0]  pgm_data_q, pgm_data_d;
    logic        pgm_we_q, pgm_we_d;
    logic        ext_wr_q, ext_wr_d;
    logic [5:0]  rst_bits_q, rst_bits_d;
    logic        rst_we_q, rst_we_d;
    logic        underrun_q, underrun_d;
    logic        overflow_q, overflow_d;

    logic       start_rise, accept, rd_half, half_change, pick;
    logic [1:0] pend_set, pend_clr;
    logic       unused_rd_low;

    assign unused_rd_low = ^snes_rd_addr[12:0];
    assign rd_half       = snes_rd_addr[13];
    assign half_change   = rd_half != rd_half_q;
    assign start_rise    = data_start_in & ~start_q;
    // A restarting seek discards whatever arrives in the same cycle.
    assign accept        = mcu_byte_strobe & fill_req_q & ~start_rise;

    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        cnt_d       = cnt_q;
        tmr_d       = tmr_q;
        fill_req_d  = fill_req_q;
        fill_half_d = fill_half_q;
        pgm_addr_d  = pgm_addr_q;
        pgm_data_d  = pgm_data_q;
        pgm_we_d    = 1'b1;
        ext_wr_d    = ext_wr_q;
        rst_bits_d  = rst_bits_q;
        rst_we_d    = rst_we_q;
        underrun_d  = underrun_q;
        overflow_d  = overflow_q;
        pend_set    = 2'b00;
        pend_clr    = 2'b00;
        pick        = ~pend_q[0];

        if (accept) begin
            pgm_we_d   = 1'b0;
            pgm_addr_d = wptr_q;
            pgm_data_d = mcu_byte;
            wptr_d     = wptr_q + 14'd1;
            cnt_d      = cnt_q + 15'd1;
        end
        if (mcu_byte_strobe && !fill_req_q) begin
            overflow_d = 1'b1;
        end

        case (state_q)
            S_PREFILL: begin
                fill_half_d = wptr_d[13];
                if (accept && cnt_q == PRE_LAST) begin
                    fill_req_d = 1'b0;
                    ext_wr_d   = 1'b1;
                    tmr_d      = TMR_LOAD;
                    state_d    = S_SEEK;
                end
            end
            S_SEEK: begin
                if (ext_wr_q) begin
                    if (tmr_q != 8'd0) tmr_d = tmr_q - 8'd1;
                    else               ext_wr_d = 1'b0;
                end else begin
                    rst_we_d   = 1'b1;
                    rst_bits_d = RELEASE_MASK;
                    tmr_d      = TMR_LOAD;
                    state_d    = S_RELEASE;
                end
            end
            S_RELEASE: begin
                // Mask is held one cycle past the strobe so the consumer
                // never samples a changing mask with the strobe high.
                if (rst_we_q) begin
                    if (tmr_q != 8'd0) tmr_d = tmr_q - 8'd1;
                    else               rst_we_d = 1'b0;
                end else begin
                    rst_bits_d = 6'd0;
                    state_d    = S_STREAM;
                end
            end
            S_STREAM: begin
                if (half_change) begin
                    pend_set[rd_half_q] = 1'b1;
                    if ((fill_req_q && fill_half_q == rd_half) || pend_q[rd_half]) begin
                        underrun_d = 1'b1;
                    end
                end
                if (fill_req_q) begin
                    if (accept && cnt_q == HALF_LAST) fill_req_d = 1'b0;
                end else if (pend_q != 2'b00) begin
                    fill_req_d     = 1'b1;
                    fill_half_d    = pick;
                    pend_clr[pick] = 1'b1;
                    wptr_d         = {pick, 13'd0};
                    cnt_d          = 15'd0;
                end
            end
            default: ;
        endcase

        pend_d = (pend_q & ~pend_clr) | pend_set;

        if (start_rise) begin
            state_d     = S_PREFILL;
            wptr_d      = 14'd0;
            cnt_d       = 15'd0;
            tmr_d       = 8'd0;
            pend_d      = 2'b00;
            fill_req_d  = 1'b1;
            fill_half_d = 1'b0;
            ext_wr_d    = 1'b0;
            rst_we_d    = 1'b0;
            rst_bits_d  = 6'd0;
            underrun_d  = 1'b0;
            overflow_d  = 1'b0;
        end
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            start_q     <= 1'b0;
            rd_half_q   <= 1'b0;
            wptr_q      <= 14'd0;
            cnt_q       <= 15'd0;
            tmr_q       <= 8'd0;
            pend_q      <= 2'b00;
            fill_req_q  <= 1'b0;
            fill_half_q <= 1'b0;
            pgm_addr_q  <= 14'd0;
            pgm_data_q  <= 8'd0;
            pgm_we_q    <= 1'b1;
            ext_wr_q    <= 1'b0;
            rst_bits_q  <= 6'd0;
            rst_we_q    <= 1'b0;
            underrun_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= data_start_in;
            rd_half_q   <= rd_half;
            wptr_q      <= wptr_d;
            cnt_q       <= cnt_d;
            tmr_q       <= tmr_d;
            pend_q      <= pend_d;
            fill_req_q  <= fill_req_d;
            fill_half_q <= fill_half_d;
            pgm_addr_q  <= pgm_addr_d;
            pgm_data_q  <= pgm_data_d;
            pgm_we_q    <= pgm_we_d;
            ext_wr_q    <= ext_wr_d;
            rst_bits_q  <= rst_bits_d;
            rst_we_q    <= rst_we_d;
            underrun_q  <= underrun_d;
            overflow_q  <= overflow_d;
        end
    end

    assign fill_req              = fill_req_q;
    assign fill_half             = fill_half_q;
    assign pgm_address           = pgm_addr_q;
    assign pgm_data              = pgm_data_q;
    assign pgm_we                = pgm_we_q;
    assign msu_address_ext       = 14'd0;
    assign msu_address_ext_write = ext_wr_q;
    assign status_reset_bits     = rst_bits_q;
    assign status_set_bits       = 6'd0;
    assign status_reset_we       = rst_we_q;
    assign underrun              = underrun_q;
    assign overflow              = overflow_q;

endmodule

// File: tb/tb_msu_data_feeder.sv
// Directed bench for msu_data_feeder. Every byte the stimulus expects to be
// written is queued as {address, data}; an independent monitor pops one
// entry per pgm_we low cycle and compares.
module tb_msu_data_feeder;

    logic        clkin = 1'b0;
    logic        reset;
    logic        data_start_in;
    logic [13:0] snes_rd_addr;
    logic [7:0]  mcu_byte;
    logic        mcu_byte_strobe;
    logic        fill_req, fill_half, pgm_we;
    logic [13:0] pgm_address, msu_address_ext;
    logic [7:0]  pgm_data;
    logic        msu_address_ext_write, status_reset_we;
    logic [5:0]  status_reset_bits, status_set_bits;
    logic        underrun, overflow;

    msu_data_feeder dut (
        .clkin(clkin), .reset(reset), .data_start_in(data_start_in),
        .snes_rd_addr(snes_rd_addr), .mcu_byte(mcu_byte),
        .mcu_byte_strobe(mcu_byte_strobe), .fill_req(fill_req),
        .fill_half(fill_half), .pgm_address(pgm_address), .pgm_data(pgm_data),
        .pgm_we(pgm_we), .msu_address_ext(msu_address_ext),
        .msu_address_ext_write(msu_address_ext_write),
        .status_reset_bits(status_reset_bits), .status_set_bits(status_set_bits),
        .status_reset_we(status_reset_we), .underrun(underrun), .overflow(overflow)
    );

    always #5 clkin = ~clkin;

    int checks = 0;
    int failures = 0;
    int wr_count = 0;
    logic [21:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor
    initial begin
        logic [21:0] e;
        forever begin
            @(negedge clkin);
            if (pgm_we === 1'b0) begin
                wr_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write actual addr=0x%0h data=0x%0h required=no write",
                             pgm_address, pgm_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_addr", 32'(pgm_address), 32'(e[21:8]));
                    chk("write_data", 32'(pgm_data), 32'(e[7:0]));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clkin);
            #1;
        end
    endtask

    task automatic wait_fill(input string name);
        int k = 0;
        while (fill_req !== 1'b1 && k < 50) begin
            cyc(1);
            k++;
        end
        chk(name, 32'(fill_req), 32'd1);
    endtask

    // Sends n bytes; byte i = i*mul+add, expected at address base+i.
    // At byte ur_at the SNES read address is moved to ur_addr.
    task automatic send(input int n, input int base, input int mul, input int add,
                        input int ur_at, input logic [13:0] ur_addr);
        logic [13:0] a;
        for (int i = 0; i < n; i++) begin
            if (i == ur_at) snes_rd_addr = ur_addr;
            a = 14'(base + i);
            if (i % 8192 == 0) chk("fill_half_progress", 32'(fill_half), 32'(a[13]));
            mcu_byte = 8'(i * mul + add);
            mcu_byte_strobe = 1'b1;
            exp_q.push_back({a, mcu_byte});
            cyc(1);
        end
        mcu_byte_strobe = 1'b0;
    endtask

    logic [11:0] s_ext, s_we, s_req;
    logic [5:0]  s_bits[12];
    int          wr_base;

    initial begin
        reset = 1'b1;
        data_start_in = 1'b0;
        snes_rd_addr = 14'd0;
        mcu_byte = 8'd0;
        mcu_byte_strobe = 1'b0;
        cyc(3);
        chk("rst_fill_req", 32'(fill_req), 0);
        chk("rst_fill_half", 32'(fill_half), 0);
        chk("rst_pgm_we", 32'(pgm_we), 1);
        chk("rst_pgm_address", 32'(pgm_address), 0);
        chk("rst_pgm_data", 32'(pgm_data), 0);
        chk("rst_ext", 32'(msu_address_ext), 0);
        chk("rst_ext_write", 32'(msu_address_ext_write), 0);
        chk("rst_status_bits", 32'(status_reset_bits), 0);
        chk("rst_status_set", 32'(status_set_bits), 0);
        chk("rst_status_we", 32'(status_reset_we), 0);
        chk("rst_underrun", 32'(underrun), 0);
        chk("rst_overflow", 32'(overflow), 0);
        reset = 1'b0;
        cyc(2);

        // Reset in the middle of a prefill
        data_start_in = 1'b1;
        cyc(1);
        wait_fill("prefill1_req");
        send(100, 0, 1, 0, -1, 14'd0);
        cyc(2);
        chk("mid_fill_req_before_reset", 32'(fill_req), 1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_fill_req", 32'(fill_req), 0);
        chk("async_rst_pgm_we", 32'(pgm_we), 1);
        chk("async_rst_pgm_address", 32'(pgm_address), 0);
        chk("async_rst_pgm_data", 32'(pgm_data), 0);
        data_start_in = 1'b0;
        cyc(2);
        reset = 1'b0;
        cyc(1);

        // Strobe in IDLE is dropped and flags overflow
        mcu_byte = 8'h5A;
        mcu_byte_strobe = 1'b1;
        cyc(1);
        mcu_byte_strobe = 1'b0;
        cyc(1);
        chk("idle_overflow", 32'(overflow), 1);
        chk("idle_no_fill", 32'(fill_req), 0);

        // Full prefill, then seek handshake
        data_start_in = 1'b1;
        cyc(1);
        wait_fill("prefill2_req");
        chk("prefill_clears_overflow", 32'(overflow), 0);
        chk("prefill_underrun", 32'(underrun), 0);
        wr_base = wr_count;
        send(16384, 0, 1, 0, -1, 14'd0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clkin);
            s_ext[k]  = msu_address_ext_write;
            s_we[k]   = status_reset_we;
            s_req[k]  = fill_req;
            s_bits[k] = status_reset_bits;
            chk("seek_ext_value", 32'(msu_address_ext), 0);
            chk("seek_status_set", 32'(status_set_bits), 0);
        end
        chk("prefill_write_count", 32'(wr_count - wr_base), 16384);
        chk("prefill_queue_empty", 32'(exp_q.size()), 0);
        chk("seek_ext_write_seq", 32'(s_ext), 32'h007);
        chk("release_we_seq", 32'(s_we), 32'h070);
        chk("handshake_fill_req", 32'(s_req), 0);
        for (int k = 0; k < 12; k++) begin
            chk("release_bits", 32'(s_bits[k]), (k >= 4 && k <= 7) ? 32'h10 : 32'h0);
        end
        cyc(1);

        // STREAM: reader leaves half 0
        snes_rd_addr = 14'h1FFF;
        cyc(2);
        chk("stream_idle_no_fill", 32'(fill_req), 0);
        snes_rd_addr = 14'h2000;
        wait_fill("refill_h0_req");
        chk("refill_h0_half", 32'(fill_half), 0);
        send(8192, 0, 3, 7, -1, 14'd0);
        chk("refill_h0_done", 32'(fill_req), 0);
        cyc(5);
        chk("refill_h0_stays_done", 32'(fill_req), 0);
        chk("no_underrun_yet", 32'(underrun), 0);

        // Reader leaves half 1; during its refill the reader re-enters it
        snes_rd_addr = 14'h0000;
        wait_fill("refill_h1_req");
        chk("refill_h1_half", 32'(fill_half), 1);
        send(8192, 14'h2000, 5, 1, 100, 14'h2000);
        chk("refill_h1_done", 32'(fill_req), 0);
        mcu_byte = 8'hAA;
        mcu_byte_strobe = 1'b1;
        cyc(1);
        mcu_byte_strobe = 1'b0;
        chk("late_strobe_overflow", 32'(overflow), 1);
        chk("refill_h1_underrun", 32'(underrun), 1);
        chk("refill_h1_queue_empty", 32'(exp_q.size()), 0);
        wait_fill("pending_h0_req");
        chk("pending_h0_half", 32'(fill_half), 0);

        // New seek clears sticky flags
        data_start_in = 1'b0;
        cyc(1);
        data_start_in = 1'b1;
        cyc(1);
        chk("restart_underrun_clr", 32'(underrun), 0);
        chk("restart_overflow_clr", 32'(overflow), 0);
        chk("restart_fill_req", 32'(fill_req), 1);
        chk("restart_fill_half", 32'(fill_half), 0);
        data_start_in = 1'b0;

        // Abort during SEEK
        send(16384, 0, 7, 3, -1, 14'd0);
        mcu_byte_strobe = 1'b1;
        cyc(1);
        mcu_byte_strobe = 1'b0;
        chk("seek_ext_before_abort", 32'(msu_address_ext_write), 1);
        chk("seek_overflow", 32'(overflow), 1);
        data_start_in = 1'b1;
        cyc(1);
        chk("abort_ext_write_drop", 32'(msu_address_ext_write), 0);
        chk("abort_fill_req", 32'(fill_req), 1);
        chk("abort_overflow_clr", 32'(overflow), 0);
        chk("abort_underrun_clr", 32'(underrun), 0);
        send(4, 0, 1, 8'h55, -1, 14'd0);
        cyc(3);
        chk("final_queue_empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
